// File: rtl/ram_arbiter_if.sv
// ============================================================================
//  Module      : ram_arbiter_if
//  Description : Bundle of the two requester ports, the RAM-side signals and
//                the status outputs of the shared data-RAM arbiter.
//                "slave" is the arbiter's view, "master" the environment's.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface ram_arbiter_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    // Port 0 (CPU MEM stage)
    logic                  req0;
    logic                  lock0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic                  wren0;
    logic [DATA_WIDTH-1:0] wdata0;
    logic                  gnt0;
    logic                  rvalid0;
    logic [DATA_WIDTH-1:0] rdata0;

    // Port 1 (host loader / debug)
    logic                  req1;
    logic                  lock1;
    logic [ADDR_WIDTH-1:0] addr1;
    logic                  wren1;
    logic [DATA_WIDTH-1:0] wdata1;
    logic                  gnt1;
    logic                  rvalid1;
    logic [DATA_WIDTH-1:0] rdata1;

    // RAM side
    logic [ADDR_WIDTH-1:0] ram_address;
    logic                  ram_wren;
    logic [DATA_WIDTH-1:0] ram_write_data;
    logic [DATA_WIDTH-1:0] ram_read_data;

    // Status
    logic [CNT_WIDTH-1:0]  conflict_count;
    logic                  locked;

    modport slave (
        input  req0, lock0, addr0, wren0, wdata0,
        output gnt0, rvalid0, rdata0,
        input  req1, lock1, addr1, wren1, wdata1,
        output gnt1, rvalid1, rdata1,
        output ram_address, ram_wren, ram_write_data,
        input  ram_read_data,
        output conflict_count, locked
    );

    modport master (
        output req0, lock0, addr0, wren0, wdata0,
        input  gnt0, rvalid0, rdata0,
        output req1, lock1, addr1, wren1, wdata1,
        input  gnt1, rvalid1, rdata1,
        input  ram_address, ram_wren, ram_write_data,
        output ram_read_data,
        input  conflict_count, locked
    );
endinterface

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ============================================================================
//  Module      : ram_arbiter
//  Description : Shares a single-port synchronous data RAM between the CPU
//                MEM stage (port 0) and the host loader (port 1). Round-robin
//                arbitration, optional lock for atomic sequences, 1-cycle
//                read latency, saturating conflict counter.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ram_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  wire logic    clk,
    input  wire logic    reset,
    ram_arbiter_if.slave bus
);

    localparam logic [1:0] ST_UNLOCKED = 2'd0;
    localparam logic [1:0] ST_LOCKED0  = 2'd1;
    localparam logic [1:0] ST_LOCKED1  = 2'd2;

    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = '1;

    logic [1:0]            r_state;
    logic                  r_rr;          // port favoured on a tie
    logic                  r_rd_valid;    // a read was granted last cycle
    logic                  r_rd_owner;    // which port that read belongs to
    logic [DATA_WIDTH-1:0] r_rdata0;
    logic [DATA_WIDTH-1:0] r_rdata1;
    logic [CNT_WIDTH-1:0]  r_conflict_count;

    logic                  w_gnt0;
    logic                  w_gnt1;
    logic [ADDR_WIDTH-1:0] w_ram_address;
    logic                  w_ram_wren;
    logic [DATA_WIDTH-1:0] w_ram_write_data;
    logic                  w_rd_grant;
    logic                  w_rvalid0;
    logic                  w_rvalid1;
    logic                  w_conflict;

    // Grant decision: lock owner exclusive, otherwise round-robin on a tie.
    // Grants are forced low while reset is held.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!reset) begin
            case (r_state)
                ST_UNLOCKED: begin
                    if (bus.req0 && bus.req1) begin
                        w_gnt0 = ~r_rr;
                        w_gnt1 = r_rr;
                    end else begin
                        w_gnt0 = bus.req0;
                        w_gnt1 = bus.req1;
                    end
                end
                ST_LOCKED0: w_gnt0 = bus.req0;
                ST_LOCKED1: w_gnt1 = bus.req1;
                default: begin
                    w_gnt0 = 1'b0;
                    w_gnt1 = 1'b0;
                end
            endcase
        end
    end

    // RAM drive: granted port's fields, all-zero when idle.
    always_comb begin
        w_ram_address    = '0;
        w_ram_wren       = 1'b0;
        w_ram_write_data = '0;
        if (w_gnt0) begin
            w_ram_address    = bus.addr0;
            w_ram_wren       = bus.wren0;
            w_ram_write_data = bus.wdata0;
        end else if (w_gnt1) begin
            w_ram_address    = bus.addr1;
            w_ram_wren       = bus.wren1;
            w_ram_write_data = bus.wdata1;
        end
    end

    assign w_rd_grant = (w_gnt0 | w_gnt1) & ~w_ram_wren;
    assign w_conflict = (bus.req0 & ~w_gnt0) | (bus.req1 & ~w_gnt1);

    // The RAM output is valid one cycle after the address, so read data is
    // passed straight through in the return cycle and held afterwards.
    assign w_rvalid0 = r_rd_valid & ~r_rd_owner;
    assign w_rvalid1 = r_rd_valid &  r_rd_owner;

    // Round-robin pointer: after any grant, favour the other port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr <= 1'b0;
        end else if (w_gnt0) begin
            r_rr <= 1'b1;
        end else if (w_gnt1) begin
            r_rr <= 1'b0;
        end
    end

    // Lock state machine: taken and released by the owner's granted access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_UNLOCKED;
        end else begin
            case (r_state)
                ST_UNLOCKED: begin
                    if (w_gnt0 && bus.lock0) begin
                        r_state <= ST_LOCKED0;
                    end else if (w_gnt1 && bus.lock1) begin
                        r_state <= ST_LOCKED1;
                    end
                end
                ST_LOCKED0: begin
                    if (w_gnt0 && !bus.lock0) begin
                        r_state <= ST_UNLOCKED;
                    end
                end
                ST_LOCKED1: begin
                    if (w_gnt1 && !bus.lock1) begin
                        r_state <= ST_UNLOCKED;
                    end
                end
                default: r_state <= ST_UNLOCKED;
            endcase
        end
    end

    // Read-return pipeline: remember a granted read and its owner.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_valid <= 1'b0;
            r_rd_owner <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_grant;
            r_rd_owner <= w_gnt1;
        end
    end

    // Hold registers keep the last returned word for each port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            if (w_rvalid0) begin
                r_rdata0 <= bus.ram_read_data;
            end
            if (w_rvalid1) begin
                r_rdata1 <= bus.ram_read_data;
            end
        end
    end

    // Saturating count of cycles in which some request was denied.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_conflict_count <= '0;
        end else if (w_conflict && (r_conflict_count != c_CNT_MAX)) begin
            r_conflict_count <= r_conflict_count + 1'b1;
        end
    end

    assign bus.gnt0           = w_gnt0;
    assign bus.gnt1           = w_gnt1;
    assign bus.rvalid0        = w_rvalid0;
    assign bus.rvalid1        = w_rvalid1;
    assign bus.rdata0         = w_rvalid0 ? bus.ram_read_data : r_rdata0;
    assign bus.rdata1         = w_rvalid1 ? bus.ram_read_data : r_rdata1;
    assign bus.ram_address    = w_ram_address;
    assign bus.ram_wren       = w_ram_wren;
    assign bus.ram_write_data = w_ram_write_data;
    assign bus.conflict_count = r_conflict_count;
    assign bus.locked         = (r_state == ST_LOCKED0) || (r_state == ST_LOCKED1);

endmodule

`default_nettype wire

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port synchronous data RAM between two requesters.
- Port 0 is the CPU MEM stage. Port 1 is the host loader/debug port, which writes programs and data and reads back results.
- Round-robin arbitration with an optional lock for atomic multi-access sequences, 1-cycle read latency and a saturating conflict counter.
- Sits between the MEM-stage RAM signals and the RAM; the stage controller holds MEM until gnt0 is seen.

Parameters:
ADDR_WIDTH, 10, RAM word-address width (matches RAM_ADDRESS_BITWIDTH)
DATA_WIDTH, 32, data word width
CNT_WIDTH, 16, width of the conflict counter

Ports:
clk  input  1  system clock; all state on rising edge
reset  input  1  asynchronous, active-high reset
req0  input  1  port 0 access request; held with addr0/wren0/wdata0 stable until gnt0
lock0  input  1  port 0 requests exclusive ownership after this access
addr0  input  ADDR_WIDTH  port 0 word address
wren0  input  1  port 0 write (1) / read (0)
wdata0  input  DATA_WIDTH  port 0 write data
gnt0  output  1  port 0 access performed this cycle
rvalid0  output  1  port 0 read data valid
rdata0  output  DATA_WIDTH  port 0 read data
req1, lock1, addr1, wren1, wdata1, gnt1, rvalid1, rdata1: same as port 0, for port 1
ram_address  output  ADDR_WIDTH  to RAM address
ram_wren  output  1  to RAM write enable
ram_write_data  output  DATA_WIDTH  to RAM write data
ram_read_data  input  DATA_WIDTH  from RAM; valid 1 cycle after address
conflict_count  output  CNT_WIDTH  cycles in which a request was denied
locked  output  1  a lock is currently held

Behaviour:
- Reset state (async, on reset=1):
  - state=UNLOCKED, rr=0 (port 0 favoured).
  - rd_owner pipeline registers cleared.
  - rvalid0/1=0, rdata0/1=0, conflict_count=0, locked=0.
  - gnt0/1=0 while reset is high.
- Grant (combinational, same cycle as req):
  - UNLOCKED:
    - Only req0 → grant port 0.
    - Only req1 → grant port 1.
    - Both → grant port rr.
  - LOCKED0: only port 0 may be granted; req1 is denied.
  - LOCKED1: mirror of LOCKED0.
- RAM drive:
  - Granted cycle: ram_address/ram_wren/ram_write_data = granted port's fields.
  - No grant: ram_wren=0, ram_address=0, ram_write_data=0.
- rr update on any grant: rr <= index of the non-granted port. No grant → rr unchanged.
- Lock state machine:
  - UNLOCKED → LOCKEDx when port x is granted with lockx=1.
  - LOCKEDx → UNLOCKED when port x is granted with lockx=0; that access still completes.
  - LOCKEDx with reqx=0 → stays LOCKEDx. No timeout; other port starves by design.
  - locked=1 in LOCKED0/LOCKED1.
- Read return:
  - Granted read (wren=0) at cycle T → rvalidx=1 at T+1 for exactly one cycle.
  - rdatax registered from ram_read_data at T+1, sampled as seen by the RAM output. Implement rd_owner/rd_valid registered at T and mux ram_read_data at T+1.
  - rdatax holds its last value when rvalidx=0.
  - Writes never produce rvalid.
- Back-to-back accesses:
  - One access per cycle, full throughput.
  - Read at T then write at T+1 to the same address: rvalid at T+1 carries the old data.
- Conflict counter:
  - Increments by 1 in each cycle with (req0 & ~gnt0) | (req1 & ~gnt1).
  - Saturates at all-ones; no wrap.
- Reset mid-operation:
  - A pending rvalid is cancelled.
  - An active lock is dropped.
- Simultaneous events:
  - Lock release and the other port's request in the same cycle → the owner is granted this cycle; the other port is granted next cycle.

Test Plan:
- Reset, then req0 read addr=0x010 (RAM holds 0xDEADBEEF) → gnt0 same cycle, ram_address=0x010, ram_wren=0; rvalid0=1 and rdata0=0xDEADBEEF next cycle, one cycle only.
- req0 and req1 both held 4 cycles, port 0 writes, port 1 reads → grants alternate 0,1,0,1; conflict_count=4; rvalid1 only in the cycles after port 1 grants.
- Port 1 writes 0x11,0x22,0x33 with lock1=1, 1, 0 while req0 is held → gnt1 three cycles, gnt0 in the 4th cycle, locked=1 for cycles 2-3, conflict_count=3.
- Assert reset one cycle after a granted read with lock0=1 → rvalid0 never asserted, locked=0, conflict_count=0, next req1 granted immediately.
- Hold req1 with lock stuck at LOCKED0 and req0=0 for 2^CNT_WIDTH+5 cycles → conflict_count saturates at 0xFFFF, gnt1 stays 0.
- No requests → ram_wren=0, ram_address=0, gnt0/1=0, rr unchanged (verify with a subsequent simultaneous request).
